// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset vector, instruction width and fetch-state encoding.
package cpu_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] RESET_PC = 32'h0000_3000;
  localparam int unsigned PC_STEP = 4;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/ifetch_buf.sv
// Synchronous FIFO for fetched {instruction, pc} entries; flush empties it in one cycle.
module ifetch_buf #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic                       valid,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A push into a full buffer is accepted only when a pop frees the head slot.
  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && ((cnt != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read while cnt says they are valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign valid = (cnt != '0);
  assign head  = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: in-order request/response fetch with redirect flush.
// Optional macro IFETCH_ALIGN_CHECK_EN enables the misaligned-redirect pulse.
module ifetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH     = INSTR_W,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [WIDTH-1:0] inst_data,
  output logic [WIDTH-1:0] inst_pc,
  output logic             misalign_err
);

  localparam int unsigned OUT_W   = $clog2(BUF_DEPTH + 1);
  localparam int unsigned SUM_W   = OUT_W + 1;
  localparam int unsigned ENTRY_W = 2 * WIDTH;

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] fpc_q, fpc_d;
  logic [WIDTH-1:0] rsp_pc_q, rsp_pc_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [OUT_W-1:0] occ;
  logic             req_valid;
  logic             req_hs;
  logic             rsp_take;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] redirect_aligned;
  logic [ENTRY_W-1:0] buf_head;

  assign redirect_aligned = redirect_pc & ~WIDTH'(3);
  assign pop              = inst_valid && inst_ready;

  // Next-state, counters and fetch PC; redirect overrides everything else.
  always_comb begin
    state_d   = state_q;
    fpc_d     = fpc_q;
    rsp_pc_d  = rsp_pc_q;
    push      = 1'b0;
    req_valid = reset && (state_q == FETCH) &&
                ((SUM_W'(out_q) + SUM_W'(occ)) < SUM_W'(BUF_DEPTH));
    req_hs    = req_valid && imem_req_ready;
    rsp_take  = imem_rsp_valid && (out_q != '0);
    out_d     = out_q + OUT_W'(req_hs) - OUT_W'(rsp_take);

    if (req_hs) fpc_d = fpc_q + WIDTH'(PC_STEP);

    case (state_q)
      FETCH: begin
        if (rsp_take) begin
          push     = 1'b1;
          rsp_pc_d = rsp_pc_q + WIDTH'(PC_STEP);
        end
      end
      FLUSH: begin
        if (out_d == '0) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    if (redirect_valid) begin
      push     = 1'b0;
      fpc_d    = redirect_aligned;
      rsp_pc_d = redirect_aligned;
      state_d  = (out_d != '0) ? FLUSH : FETCH;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= FETCH;
      fpc_q    <= WIDTH'(RESET_PC);
      rsp_pc_q <= WIDTH'(RESET_PC);
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
    end
  end

  ifetch_buf #(
    .DEPTH (BUF_DEPTH),
    .W     (ENTRY_W)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({imem_rsp_data, rsp_pc_q}),
    .pop       (pop),
    .valid     (inst_valid),
    .head      (buf_head),
    .count     (occ)
  );

  assign imem_req_valid = req_valid;
  assign imem_req_addr  = fpc_q;
  assign inst_data      = buf_head[ENTRY_W-1:WIDTH];
  assign inst_pc        = buf_head[WIDTH-1:0];

`ifdef IFETCH_ALIGN_CHECK_EN
  // One-cycle pulse for a redirect target that is not word aligned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) misalign_err <= 1'b0;
    else        misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
  end
`else
  assign misalign_err = 1'b0;
`endif

endmodule
